mp3_word_prefetch: RTL and testbench

//  Upstream feeder for the VS1003 SPI streamer. Walks a block-ROM address range
//  (one track) with a 1-cycle-latency synchronous ROM and buffers words in a small FIFO.

---
 rtl/mp3_word_prefetch.sv | 124 ++++++++++++
 tb/tb_mp3_word_prefetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_word_prefetch.sv
// Track prefetcher for the VS1003 streamer: walks a ROM address range through a
// 1-cycle synchronous ROM into a small FIFO and serves words on a valid/ready port.
module mp3_word_prefetch #(
   parameter int WIDTH     = 32,
   parameter int AW        = 14,
   parameter int FIFO_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 play,
   input  logic                 loop,
   input  logic [AW-1:0]        start_addr,
   input  logic [AW-1:0]        end_addr,
   output logic                 rom_en,
   output logic [AW-1:0]        rom_addr,
   input  logic [WIDTH-1:0]     rom_data,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done,
   output logic [FIFO_LOG2:0]   level
);

   localparam int DEPTH = 1 << FIFO_LOG2;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                 state, state_nx;
   logic                   play_q, inflight, done_q;
   logic [AW-1:0]          cur, start_l, end_l;
   logic [WIDTH-1:0]       mem [DEPTH];
   logic [FIFO_LOG2-1:0]   wr_ptr, rd_ptr;
   logic [FIFO_LOG2:0]     cnt;
   logic [FIFO_LOG2+1:0]   occ;
   logic                   rise, stop, empty_range, at_end, issue, push, pop;

   assign rise        = play & ~play_q;
   assign stop        = (state != IDLE) & ~play;
   assign empty_range = end_addr < start_addr;
   assign at_end      = cur == end_l;
   // Reserve a slot for the word still coming back from the ROM.
   assign occ         = {1'b0, cnt} + (FIFO_LOG2+2)'(inflight);
   assign push        = inflight & ~stop;
   assign pop         = out_valid & out_ready & ~stop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rise && !empty_range) state_nx = FETCH;
         FETCH:   if (stop) state_nx = IDLE;
                  else if (issue && at_end && !loop) state_nx = DRAIN;
         DRAIN:   if (stop) state_nx = IDLE;
                  else if (cnt == '0 && !inflight) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      issue    = (state == FETCH) && (occ < (FIFO_LOG2+2)'(DEPTH));
      rom_en   = issue;
      rom_addr = issue ? cur : '0;
      busy     = state != IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         play_q   <= 1'b0;
         inflight <= 1'b0;
         done_q   <= 1'b0;
         cur      <= '0;
         start_l  <= '0;
         end_l    <= '0;
      end else begin
         play_q   <= play;
         inflight <= issue & ~stop;
         done_q   <= (state == IDLE && rise && empty_range) ||
                     (state == DRAIN && !stop && cnt == '0 && !inflight);
         if (state == IDLE && rise) begin
            start_l <= start_addr;
            end_l   <= end_addr;
            cur     <= start_addr;
         end else if (issue) begin
            cur <= at_end ? start_l : cur + 1'b1;
         end
      end
   end

   // Stop flushes everything; the word returning from the ROM is dropped via push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (stop) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rom_data;
   end

   assign out_valid = cnt != '0;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign level     = cnt;
   assign done      = done_q;

endmodule

// File: tb/tb_mp3_word_prefetch.sv
// Randomized scoreboard bench for mp3_word_prefetch: expected words come from a ROM
// image and the track range; a negedge monitor pops and compares on each handshake.
module tb_mp3_word_prefetch;
   localparam int W = 32, AW = 14, L = 3;

   logic          clk = 1'b0;
   logic          rst, play, loop, out_ready;
   logic [AW-1:0] start_addr, end_addr, rom_addr;
   logic          rom_en, out_valid, busy, done;
   logic [W-1:0]  rom_data = '0, out_data;
   logic [L:0]    level;

   logic [W-1:0]  rom_mem [1<<AW];
   logic [W-1:0]  exp_q [$];
   int errors = 0, checks = 0, pops = 0, dones = 0, rom_reads = 0;

   mp3_word_prefetch #(.WIDTH(W), .AW(AW), .FIFO_LOG2(L)) dut (
      .clk(clk), .rst(rst), .play(play), .loop(loop),
      .start_addr(start_addr), .end_addr(end_addr),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .level(level));

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL word_unexpected: got %0h with nothing expected", out_data);
            end else begin
               check("word", out_data, exp_q.pop_front());
            end
            pops++;
         end
         if (done) dones++;
         if (rom_en) rom_reads++;
         check("level_bound", level <= 8, 1);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_track(input int s, input int e, input bit lp);
      start_addr = AW'(s);
      end_addr   = AW'(e);
      loop       = lp;
      play       = 1'b1;
      if (!lp && e >= s)
         for (int a = s; a <= e; a++) exp_q.push_back(rom_mem[a]);
   endtask

   task automatic wait_done(input int limit, input bit rnd);
      int k = 0;
      while (!done && k < limit) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      check("done_within_bound", done, 1);
   endtask

   initial begin
      int p0, d0, r0, k, s, len;
      for (int i = 0; i < (1<<AW); i++) rom_mem[i] = $urandom;
      rst = 1'b0; play = 1'b0; loop = 1'b0; out_ready = 1'b0;
      start_addr = '0; end_addr = '0;
      #12;
      check("rst_rom_en", rom_en, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_level", level, 0);
      check("rst_out_data", out_data, 0);
      tick();
      rst = 1'b1;
      tick();

      // T1: short track, first-word latency and single done
      out_ready = 1'b1;
      start_track(0, 3, 0);
      tick(); check("t1_lat_c1", out_valid, 0);
      tick(); check("t1_lat_c2", out_valid, 0);
      tick(); check("t1_lat_c3", out_valid, 1);
      wait_done(50, 0);
      check("t1_pops_at_done", pops, 4);
      check("t1_busy_with_done", busy, 0);
      play = 1'b0;
      tick();
      check("t1_done_once", dones, 1);
      check("t1_queue_empty", exp_q.size(), 0);

      // T2: back-pressure saturates the FIFO
      out_ready = 1'b0;
      r0 = rom_reads; p0 = pops;
      start_track(0, 19, 0);
      tick(20);
      check("t2_level_full", level, 8);
      check("t2_rom_en_gated", rom_en, 0);
      check("t2_reads_gated", rom_reads - r0, 8);
      check("t2_out_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_done(200, 0);
      check("t2_pops", pops - p0, 20);
      check("t2_queue_empty", exp_q.size(), 0);
      play = 1'b0;
      tick();

      // T3: looping track never finishes
      d0 = dones; p0 = pops;
      out_ready = 1'b1;
      start_track(5, 6, 1);
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(rom_mem[5]);
         exp_q.push_back(rom_mem[6]);
      end
      k = 0;
      while (pops - p0 < 20 && k < 100) begin tick(); k++; end
      check("t3_20_words", pops - p0 >= 20, 1);
      check("t3_no_done", dones, d0);
      play = 1'b0;
      tick();
      check("t3_stop_valid", out_valid, 0);
      check("t3_stop_level", level, 0);
      check("t3_stop_busy", busy, 0);
      exp_q.delete();
      tick();
      check("t3_stop_no_done", dones, d0);

      // T4: abort with level 5 and a read in flight, then clean restart
      out_ready = 1'b0;
      start_track(100, 199, 0);
      k = 0;
      while (level != 5 && k < 50) begin tick(); k++; end
      check("t4_level5", level, 5);
      check("t4_read_active", rom_en, 1);
      play = 1'b0;
      tick();
      check("t4_valid", out_valid, 0);
      check("t4_level", level, 0);
      check("t4_busy", busy, 0);
      check("t4_done", done, 0);
      exp_q.delete();
      tick(2);
      check("t4_pending_dropped", level, 0);
      p0 = pops;
      out_ready = 1'b1;
      start_track(100, 103, 0);
      wait_done(50, 0);
      check("t4_restart_pops", pops - p0, 4);
      check("t4_restart_queue", exp_q.size(), 0);
      play = 1'b0;
      tick();

      // T5: end before start
      r0 = rom_reads; d0 = dones;
      start_track(10, 9, 0);
      tick();
      check("t5_done_pulse", done, 1);
      check("t5_busy", busy, 0);
      tick();
      check("t5_done_low", done, 0);
      play = 1'b0;
      tick(3);
      check("t5_no_reads", rom_reads - r0, 0);
      check("t5_one_done", dones - d0, 1);
      check("t5_no_valid", out_valid, 0);

      // Random tracks with random back-pressure
      for (int t = 0; t < 8; t++) begin
         d0 = dones;
         s = int'($urandom_range(0, 500));
         len = int'($urandom_range(1, 30));
         start_track(s, s + len - 1, 0);
         wait_done(2000, 1);
         play = 1'b0;
         tick();
         check("rnd_queue_empty", exp_q.size(), 0);
         check("rnd_one_done", dones - d0, 1);
      end

      // T6: asynchronous reset mid-fetch, off the clock edge
      out_ready = 1'b1;
      start_track(300, 399, 0);
      tick(6);
      #3;
      rst = 1'b0;
      #1;
      check("t6_rom_en", rom_en, 0);
      check("t6_rom_addr", rom_addr, 0);
      check("t6_out_valid", out_valid, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_level", level, 0);
      check("t6_out_data", out_data, 0);
      exp_q.delete();
      play = 1'b0;
      tick();
      rst = 1'b1;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
